dii_packet_fifo: RTL and testbench
==================================

# dii_packet_fifo

Parametrised packet FIFO for Debug Interconnect Interface (DII) channels, and the successor to the small shift-register buffer.
- Stores flits in a circular buffer of power-of-two depth, addressed by read/write pointers.
- Tracks complete packets and reports fill level, packet count and head-packet size.
- Optional full-packet release and optional drop-on-overflow let a non-stalling source sit in front of a congested DII ring.

## Interface
Parameters:
- WIDTH, 16, flit data width
- DEPTH, 16, flit capacity; power of two, ≥2
- FULLPACKET, 0, 1 = out.valid only while at least one complete packet is stored

Ports (CW = $clog2(DEPTH)+1):
- clk  input  1  single clock, all logic on rising edge
- rst  input  1  synchronous, active-high reset
- in  dii_channel (slave)  data WIDTH, last 1, valid 1, ready 1  flit input
- out  dii_channel (master)  data WIDTH, last 1, valid 1, ready 1  flit output
- fill_level  output  CW  flits stored, 0..DEPTH
- packet_count  output  CW  complete packets stored (last flit written, not yet popped)
- head_size  output  CW  flit count of oldest complete packet; 0 if packet_count==0

## Operation
- push = in.valid & in.ready; pop = out.valid & out.ready.
- Flits are written at wr_ptr and read at rd_ptr. Pointers are CW bits wide, wrap modulo 2·DEPTH and address with the low CW-1 bits.
- Full: wr_ptr−rd_ptr==DEPTH. Empty: equal.
- in.ready = !full. It is decided from registered state, so it stays low when full even if a pop occurs in the same cycle.
- out.data/out.last come from mem[rd_ptr]. FULLPACKET=0: out.valid = !empty.
- FULLPACKET=1: out.valid = (packet_count!=0) | full. The full escape prevents deadlock on packets longer than DEPTH.
- Length side-FIFO (DEPTH entries, CW bits wide):
  - A running length counter increments on each push.
  - On push of a last flit it enqueues counter+1 and clears the counter.
  - The entry is dequeued on pop of a last flit.
  - head_size = side-FIFO head.
- packet_count increments on push of a last flit and decrements on pop of a last flit; both in the same cycle leaves it unchanged.
- fill_level tracks push/pop the same way.
- Reset: pointers, counters and side-FIFO are cleared. Stored data is discarded (memory need not be cleared). Reset mid-packet discards the partial packet.

## Timing
- Reset values: out.valid 0, in.ready 1, fill_level 0, packet_count 0, head_size 0, drop_count 0 (when present). out.data/out.last are don't-care while out.valid=0.
- Latency FULLPACKET=0: a flit pushed in cycle N is at the output with out.valid=1 in N+1. There is no same-cycle bypass when empty.
- Latency FULLPACKET=1: the first flit is valid in the cycle after the last flit of its packet is pushed.
- Throughput: 1 flit/cycle with simultaneous push and pop at any fill level except full (no push) and empty (no pop).
- out.valid never deasserts without a pop. out.data is stable while valid & !ready.
- Status outputs are registered or derived from registered state only and update the cycle after the event.

## Configuration
- OSD_DII_FIFO_DROP_EN undefined: backpressure mode exactly as above.
- OSD_DII_FIFO_DROP_EN defined:
  - in.ready is tied to 1.
  - A commit pointer marks the end of the last complete packet written.
  - out.valid only covers committed flits, whatever the FULLPACKET setting.
  - Adds output drop_count [15:0], a saturating count of dropped packets.
  - FSM ACCEPT: a valid flit arriving while full rewinds wr_ptr to the commit pointer, clears the length counter and increments drop_count. If that flit is not last, the FSM goes to DISCARD; if it is last, it stays in ACCEPT.
  - FSM DISCARD: flits are consumed without being stored; in.last returns the FSM to ACCEPT.
  - Consequence: packets longer than DEPTH are always dropped.
  - fill_level includes uncommitted flits.

## Test plan
- Reset, then push 3 single-flit packets (0x0001..0x0003) with out.ready=0 -> fill_level=3, packet_count=3, head_size=1, out.data=0x0001.
- DEPTH=16: push 16 flits with no last and out.ready=0 -> in.ready=0 after the 16th. FULLPACKET=1: out.valid=1 via the full escape. Then pop 1 -> in.ready=1 next cycle.
- FULLPACKET=1: push a 4-flit packet one flit per cycle, cycles 0-3 -> out.valid=0 through cycle 3, 1 in cycle 4, head_size=4. Pop all -> packet_count=0, head_size=0.
- Continuous push and pop for 100 flits across pointer wrap, random out.ready -> output sequence equals input sequence, fill_level never exceeds 16.
- Assert rst mid-packet (2 of 5 flits pushed) -> next cycle fill_level=0 and out.valid=0. A new 1-flit packet then emerges alone.
- DROP_EN, DEPTH=16: store 2 complete 7-flit packets (14 flits), then push a 5-flit packet with out.ready=0 -> the third flit of it hits full, the packet is discarded, drop_count=1, fill_level=14, packet_count=2.

Source files
------------

// File: rtl/dii_packet_fifo.sv
// Packet FIFO for DII channels: circular flit buffer with packet bookkeeping.
// Define OSD_DII_FIFO_DROP_EN to replace backpressure with whole-packet drop on overflow.
module dii_packet_fifo #(
  parameter int WIDTH      = 16,
  parameter int DEPTH      = 16,
  parameter int FULLPACKET = 0,
  localparam int CW        = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CW-1:0]    fill_level,
  output logic [CW-1:0]    packet_count,
  output logic [CW-1:0]    head_size
`ifdef OSD_DII_FIFO_DROP_EN
  ,
  output logic [15:0]      drop_count
`endif
);

  localparam int AW = CW - 1;

  logic [WIDTH:0]  mem     [DEPTH];
  logic [CW-1:0]   len_mem [DEPTH];
  logic [CW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   len_wr, len_rd, len_cnt, pkt_cnt;
  logic            full, store, pop;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign fill_level   = wr_ptr - rd_ptr;
  assign full         = (fill_level == CW'(DEPTH));
  assign packet_count = pkt_cnt;
  assign pop          = out_valid & out_ready;
  assign {out_last, out_data} = mem[rd_ptr[AW-1:0]];

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    head_size = '0;
    if (pkt_cnt != '0) head_size = len_mem[len_rd[AW-1:0]];
  end

`ifdef OSD_DII_FIFO_DROP_EN
  typedef enum logic {ACCEPT, DISCARD} drop_state_t;

  drop_state_t   state, state_next;
  logic [CW-1:0] commit_ptr;
  logic          rewind;

  assign in_ready  = 1'b1;
  assign out_valid = (rd_ptr != commit_ptr);

  always_comb begin
    state_next = state;
    store      = 1'b0;
    rewind     = 1'b0;
    case (state)
      ACCEPT: begin
        if (in_valid) begin
          if (full) begin
            rewind = 1'b1;
            if (!in_last) state_next = DISCARD;
          end else begin
            store = 1'b1;
          end
        end
      end
      DISCARD: if (in_valid && in_last) state_next = ACCEPT;
      default: state_next = ACCEPT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ACCEPT;
      commit_ptr <= '0;
      drop_count <= '0;
    end else begin
      state <= state_next;
      if (store && in_last) commit_ptr <= wr_ptr + 1'b1;
      if (rewind && drop_count != 16'hFFFF) drop_count <= drop_count + 1'b1;
    end
  end
`else
  logic empty;

  // in_ready looks only at registered state, so a same-cycle pop never frees a slot.
  assign empty     = (wr_ptr == rd_ptr);
  assign in_ready  = !full;
  assign store     = in_valid & in_ready;
  // The full escape lets packets longer than DEPTH drain before their last flit arrives.
  assign out_valid = (FULLPACKET != 0) ? ((pkt_cnt != '0) || full) : !empty;
`endif

  // NOTE: state updates use <= so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      len_wr  <= '0;
      len_rd  <= '0;
      len_cnt <= '0;
      pkt_cnt <= '0;
    end else begin
`ifdef OSD_DII_FIFO_DROP_EN
      if (rewind) begin
        wr_ptr  <= commit_ptr;
        len_cnt <= '0;
      end else
`endif
      if (store) begin
        wr_ptr  <= wr_ptr + 1'b1;
        len_cnt <= in_last ? '0 : len_cnt + 1'b1;
        if (in_last) len_wr <= len_wr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (pop && out_last) len_rd <= len_rd + 1'b1;
      if ((store && in_last) != (pop && out_last))
        pkt_cnt <= (store && in_last) ? pkt_cnt + 1'b1 : pkt_cnt - 1'b1;
    end
  end

  // NOTE: storage arrays have no reset; the pointers alone decide what is valid.
  always_ff @(posedge clk) begin
    if (store) begin
      mem[wr_ptr[AW-1:0]] <= {in_last, in_data};
      if (in_last) len_mem[len_wr[AW-1:0]] <= len_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_dii_packet_fifo.sv
// Directed bench for dii_packet_fifo: instance 0 has FULLPACKET=0, instance 1 FULLPACKET=1.
`timescale 1ns/1ps
module tb_dii_packet_fifo;

  localparam int W  = 16;
  localparam int CW = 5;
`ifdef OSD_DII_FIFO_DROP_EN
  localparam bit DROP = 1'b1;
`else
  localparam bit DROP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic [W-1:0]  in_data      [2];
  logic          in_last      [2];
  logic          in_valid     [2];
  logic          in_ready     [2];
  logic [W-1:0]  out_data     [2];
  logic          out_last     [2];
  logic          out_valid    [2];
  logic          out_ready    [2];
  logic [CW-1:0] fill_level   [2];
  logic [CW-1:0] packet_count [2];
  logic [CW-1:0] head_size    [2];
`ifdef OSD_DII_FIFO_DROP_EN
  logic [15:0]   drop_count   [2];
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dii_packet_fifo #(.WIDTH(W), .DEPTH(16), .FULLPACKET(0)) u_fp0 (
    .clk(clk), .rst(rst),
    .in_data(in_data[0]), .in_last(in_last[0]), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .out_data(out_data[0]), .out_last(out_last[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .fill_level(fill_level[0]), .packet_count(packet_count[0]), .head_size(head_size[0])
`ifdef OSD_DII_FIFO_DROP_EN
    , .drop_count(drop_count[0])
`endif
  );

  dii_packet_fifo #(.WIDTH(W), .DEPTH(16), .FULLPACKET(1)) u_fp1 (
    .clk(clk), .rst(rst),
    .in_data(in_data[1]), .in_last(in_last[1]), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .out_data(out_data[1]), .out_last(out_last[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .fill_level(fill_level[1]), .packet_count(packet_count[1]), .head_size(head_size[1])
`ifdef OSD_DII_FIFO_DROP_EN
    , .drop_count(drop_count[1])
`endif
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_in(input logic v, input logic [W-1:0] d, input logic l);
    for (int u = 0; u < 2; u++) begin
      in_valid[u] = v;
      in_data[u]  = d;
      in_last[u]  = l;
    end
  endtask

  task automatic set_ready(input logic r);
    for (int u = 0; u < 2; u++) out_ready[u] = r;
  endtask

  task automatic do_reset();
    drive_in(1'b0, '0, 1'b0);
    set_ready(1'b0);
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    for (int u = 0; u < 2; u++) begin
      checks++;
      if ({out_valid[u], in_ready[u], fill_level[u], packet_count[u], head_size[u]} !==
          {1'b0, 1'b1, 5'd0, 5'd0, 5'd0}) begin
        errors++;
        $display("FAIL reset_state[%0d]: got %h, expected %h", u,
                 {out_valid[u], in_ready[u], fill_level[u], packet_count[u], head_size[u]},
                 {1'b0, 1'b1, 5'd0, 5'd0, 5'd0});
      end
`ifdef OSD_DII_FIFO_DROP_EN
      checks++;
      if (drop_count[u] !== 16'd0) begin
        errors++;
        $display("FAIL reset_drop_count[%0d]: got %0d, expected 0", u, drop_count[u]);
      end
`endif
    end
  endtask

  task automatic test_single_packets();
    do_reset();
    for (int i = 1; i <= 3; i++) begin
      drive_in(1'b1, W'(i), 1'b1);
      step();
      if (i == 1) begin
        for (int u = 0; u < 2; u++) begin
          checks++;
          if (out_valid[u] !== 1'b1) begin
            errors++;
            $display("FAIL first_flit_latency[%0d]: got valid %b, expected 1", u, out_valid[u]);
          end
        end
      end
    end
    drive_in(1'b0, '0, 1'b0);
    for (int u = 0; u < 2; u++) begin
      checks++;
      if ({fill_level[u], packet_count[u], head_size[u], out_valid[u], out_data[u]} !==
          {5'd3, 5'd3, 5'd1, 1'b1, 16'h0001}) begin
        errors++;
        $display("FAIL three_singles[%0d]: got %h, expected %h", u,
                 {fill_level[u], packet_count[u], head_size[u], out_valid[u], out_data[u]},
                 {5'd3, 5'd3, 5'd1, 1'b1, 16'h0001});
      end
    end
    set_ready(1'b1);
    for (int k = 0; k < 3; k++) begin
      for (int u = 0; u < 2; u++) begin
        checks++;
        if ({out_last[u], out_data[u]} !== {1'b1, W'(k + 1)}) begin
          errors++;
          $display("FAIL single_drain[%0d]: got %h, expected %h", u,
                   {out_last[u], out_data[u]}, {1'b1, W'(k + 1)});
        end
      end
      step();
    end
    set_ready(1'b0);
    for (int u = 0; u < 2; u++) begin
      checks++;
      if ({out_valid[u], fill_level[u], packet_count[u], head_size[u]} !== {1'b0, 15'd0}) begin
        errors++;
        $display("FAIL single_empty[%0d]: got %h, expected 0", u,
                 {out_valid[u], fill_level[u], packet_count[u], head_size[u]});
      end
    end
  endtask

  task automatic test_full();
    do_reset();
    for (int i = 0; i < 16; i++) begin
      drive_in(1'b1, 16'h0100 + W'(i), 1'b0);
      step();
      for (int u = 0; u < 2; u++) begin
        checks++;
        if (in_ready[u] !== (i < 15)) begin
          errors++;
          $display("FAIL full_ready[%0d] after flit %0d: got %b, expected %b", u, i, in_ready[u], i < 15);
        end
      end
    end
    drive_in(1'b0, '0, 1'b0);
    for (int u = 0; u < 2; u++) begin
      checks++;
      if ({out_valid[u], fill_level[u], packet_count[u], head_size[u], out_data[u]} !==
          {1'b1, 5'd16, 5'd0, 5'd0, 16'h0100}) begin
        errors++;
        $display("FAIL full_state[%0d]: got %h, expected %h", u,
                 {out_valid[u], fill_level[u], packet_count[u], head_size[u], out_data[u]},
                 {1'b1, 5'd16, 5'd0, 5'd0, 16'h0100});
      end
    end
    // Push offered alongside the pop must be refused while full.
    drive_in(1'b1, 16'hBEEF, 1'b0);
    set_ready(1'b1);
    step();
    drive_in(1'b0, '0, 1'b0);
    set_ready(1'b0);
    for (int u = 0; u < 2; u++) begin
      checks++;
      if ({in_ready[u], fill_level[u], out_data[u]} !== {1'b1, 5'd15, 16'h0101}) begin
        errors++;
        $display("FAIL full_pop[%0d]: got %h, expected %h", u,
                 {in_ready[u], fill_level[u], out_data[u]}, {1'b1, 5'd15, 16'h0101});
      end
    end
  endtask

`ifdef OSD_DII_FIFO_DROP_EN
  task automatic test_drop();
    logic [W-1:0] exp;
    do_reset();
    for (int p = 0; p < 2; p++)
      for (int k = 0; k < 7; k++) begin
        drive_in(1'b1, 16'h0400 + W'(p * 16 + k), k == 6);
        step();
      end
    for (int k = 0; k < 5; k++) begin
      drive_in(1'b1, 16'h0500 + W'(k), k == 4);
      step();
    end
    drive_in(1'b0, '0, 1'b0);
    for (int u = 0; u < 2; u++) begin
      checks++;
      if ({drop_count[u], fill_level[u], packet_count[u], head_size[u], in_ready[u], out_valid[u]} !==
          {16'd1, 5'd14, 5'd2, 5'd7, 1'b1, 1'b1}) begin
        errors++;
        $display("FAIL drop_state[%0d]: got %h, expected %h", u,
                 {drop_count[u], fill_level[u], packet_count[u], head_size[u], in_ready[u], out_valid[u]},
                 {16'd1, 5'd14, 5'd2, 5'd7, 1'b1, 1'b1});
      end
    end
    drive_in(1'b1, 16'h0600, 1'b1);
    step();
    drive_in(1'b0, '0, 1'b0);
    for (int u = 0; u < 2; u++) begin
      checks++;
      if ({fill_level[u], packet_count[u]} !== {5'd15, 5'd3}) begin
        errors++;
        $display("FAIL drop_recover[%0d]: got %h, expected %h", u,
                 {fill_level[u], packet_count[u]}, {5'd15, 5'd3});
      end
    end
    set_ready(1'b1);
    for (int j = 0; j < 15; j++) begin
      exp = (j < 7) ? 16'h0400 + W'(j) : (j < 14) ? 16'h0410 + W'(j - 7) : 16'h0600;
      for (int u = 0; u < 2; u++) begin
        checks++;
        if (out_data[u] !== exp) begin
          errors++;
          $display("FAIL drop_drain[%0d] flit %0d: got %h, expected %h", u, j, out_data[u], exp);
        end
      end
      step();
    end
    set_ready(1'b0);
    for (int u = 0; u < 2; u++) begin
      checks++;
      if ({fill_level[u], out_valid[u], drop_count[u]} !== {5'd0, 1'b0, 16'd1}) begin
        errors++;
        $display("FAIL drop_final[%0d]: got %h, expected %h", u,
                 {fill_level[u], out_valid[u], drop_count[u]}, {5'd0, 1'b0, 16'd1});
      end
    end
  endtask
`endif

  task automatic test_fullpacket();
    logic exp_v;
    do_reset();
    for (int u = 0; u < 2; u++) begin
      checks++;
      if (out_valid[u] !== 1'b0) begin
        errors++;
        $display("FAIL fp_cycle0[%0d]: got valid %b, expected 0", u, out_valid[u]);
      end
    end
    for (int k = 0; k < 4; k++) begin
      drive_in(1'b1, 16'h0200 + W'(k), k == 3);
      step();
      for (int u = 0; u < 2; u++) begin
        exp_v = (u == 1 || DROP) ? (k == 3) : 1'b1;
        checks++;
        if (out_valid[u] !== exp_v) begin
          errors++;
          $display("FAIL fp_valid[%0d] after flit %0d: got %b, expected %b", u, k, out_valid[u], exp_v);
        end
      end
    end
    drive_in(1'b0, '0, 1'b0);
    for (int u = 0; u < 2; u++) begin
      checks++;
      if ({fill_level[u], packet_count[u], head_size[u]} !== {5'd4, 5'd1, 5'd4}) begin
        errors++;
        $display("FAIL fp_head[%0d]: got %h, expected %h", u,
                 {fill_level[u], packet_count[u], head_size[u]}, {5'd4, 5'd1, 5'd4});
      end
    end
    set_ready(1'b1);
    for (int k = 0; k < 4; k++) begin
      for (int u = 0; u < 2; u++) begin
        checks++;
        if ({out_last[u], out_data[u]} !== {k == 3, 16'h0200 + W'(k)}) begin
          errors++;
          $display("FAIL fp_drain[%0d] flit %0d: got %h, expected %h", u, k,
                   {out_last[u], out_data[u]}, {k == 3, 16'h0200 + W'(k)});
        end
      end
      step();
    end
    set_ready(1'b0);
    for (int u = 0; u < 2; u++) begin
      checks++;
      if ({out_valid[u], fill_level[u], packet_count[u], head_size[u]} !== {1'b0, 15'd0}) begin
        errors++;
        $display("FAIL fp_empty[%0d]: got %h, expected 0", u,
                 {out_valid[u], fill_level[u], packet_count[u], head_size[u]});
      end
    end
  endtask

  task automatic test_stream();
    int sent, rcv, cyc;
    for (int u = 0; u < 2; u++) begin
      do_reset();
      sent = 0;
      rcv  = 0;
      cyc  = 0;
      while (rcv < 100 && cyc < 2000) begin
        in_valid[u]  = (sent < 100) && ($urandom_range(0, 1) == 1);
        in_data[u]   = 16'h1000 + W'(sent);
        in_last[u]   = (sent % 4 == 3);
        out_ready[u] = ($urandom_range(0, 3) != 0);
        if (in_valid[u] && in_ready[u]) sent++;
        if (out_valid[u] && out_ready[u]) begin
          checks++;
          if ({out_last[u], out_data[u]} !== {rcv % 4 == 3, 16'h1000 + W'(rcv)}) begin
            errors++;
            $display("FAIL stream_data[%0d] flit %0d: got %h, expected %h", u, rcv,
                     {out_last[u], out_data[u]}, {rcv % 4 == 3, 16'h1000 + W'(rcv)});
          end
          rcv++;
        end
        checks++;
        if (fill_level[u] > 5'd16) begin
          errors++;
          $display("FAIL stream_fill[%0d]: got %0d, expected <= 16", u, fill_level[u]);
        end
        step();
        cyc++;
      end
      in_valid[u]  = 1'b0;
      out_ready[u] = 1'b0;
      checks++;
      if (rcv != 100) begin
        errors++;
        $display("FAIL stream_timeout[%0d]: got %0d flits, expected 100", u, rcv);
      end
      checks++;
      if ({fill_level[u], out_valid[u]} !== {5'd0, 1'b0}) begin
        errors++;
        $display("FAIL stream_end[%0d]: got %h, expected 0", u, {fill_level[u], out_valid[u]});
      end
    end
  endtask

  task automatic test_reset_mid_packet();
    do_reset();
    for (int k = 0; k < 2; k++) begin
      drive_in(1'b1, 16'h0300 + W'(k), 1'b0);
      step();
    end
    drive_in(1'b0, '0, 1'b0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int u = 0; u < 2; u++) begin
      checks++;
      if ({fill_level[u], out_valid[u], packet_count[u]} !== {5'd0, 1'b0, 5'd0}) begin
        errors++;
        $display("FAIL midreset[%0d]: got %h, expected 0", u,
                 {fill_level[u], out_valid[u], packet_count[u]});
      end
    end
    drive_in(1'b1, 16'h0AAA, 1'b1);
    step();
    drive_in(1'b0, '0, 1'b0);
    for (int u = 0; u < 2; u++) begin
      checks++;
      if ({out_valid[u], out_last[u], out_data[u], fill_level[u], packet_count[u], head_size[u]} !==
          {1'b1, 1'b1, 16'h0AAA, 5'd1, 5'd1, 5'd1}) begin
        errors++;
        $display("FAIL midreset_new[%0d]: got %h, expected %h", u,
                 {out_valid[u], out_last[u], out_data[u], fill_level[u], packet_count[u], head_size[u]},
                 {1'b1, 1'b1, 16'h0AAA, 5'd1, 5'd1, 5'd1});
      end
    end
    set_ready(1'b1);
    step();
    set_ready(1'b0);
    for (int u = 0; u < 2; u++) begin
      checks++;
      if ({out_valid[u], fill_level[u]} !== {1'b0, 5'd0}) begin
        errors++;
        $display("FAIL midreset_alone[%0d]: got %h, expected 0", u, {out_valid[u], fill_level[u]});
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    drive_in(1'b0, '0, 1'b0);
    set_ready(1'b0);
    test_reset();
    test_single_packets();
`ifdef OSD_DII_FIFO_DROP_EN
    test_drop();
`else
    test_full();
`endif
    test_fullpacket();
    test_stream();
    test_reset_mid_packet();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
